// File: rtl/dhm_pd_ctrl.sv
// Power-down sequencer for one DHM core power domain: retention save/restore,
// sleep handshake with the power switch chain and sticky ack-timeout reporting.
module dhm_pd_ctrl #(
  parameter int unsigned SAVE_CYCLES    = 4,
  parameter int unsigned RESTORE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT    = 200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pwr_dn_req,
  input  logic       pwr_up_req,
  input  logic       sleep_ack,
  input  logic       err_clr,
  output logic [2:0] pd_state,
  output logic       rreg_save,
  output logic       rreg_restore,
  output logic       pd_on,
  output logic       pd_busy,
  output logic       ack_timeout
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] SAVE_LAST    = CNT_W'(SAVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESTORE_LAST = CNT_W'(RESTORE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST     = CNT_W'(ACK_TIMEOUT - 1);

  // bit1 of the encoding marks the domain as powered
  typedef enum logic [2:0] {
    ST_OFF     = 3'b000,
    ST_SLEEP   = 3'b001,
    ST_WAKE    = 3'b010,
    ST_RESTORE = 3'b011,
    ST_ON      = 3'b110,
    ST_SAVE    = 3'b111
  } state_t;

  state_t           state_q;
  state_t           state_nxt;
  logic [1:0]       sync_q;
  logic             sack;
  logic [CNT_W-1:0] cnt_q;
  logic             ctx_valid_q;
  logic             timeout_set;
  logic             ctx_set;
  logic             counting;

  assign sack     = sync_q[1];
  assign pd_state = state_q;
  assign counting = (state_q == ST_WAKE) || (state_q == ST_SLEEP) ||
                    (state_q == ST_SAVE) || (state_q == ST_RESTORE);

  // Next-state selection; a timeout takes the same exit as a real ack
  always_comb begin
    state_nxt   = state_q;
    timeout_set = 1'b0;
    ctx_set     = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (pwr_up_req) state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        if (!sack || cnt_q >= ACK_LAST) begin
          timeout_set = sack;
          if (ctx_valid_q) state_nxt = ST_RESTORE;
          else             state_nxt = ST_ON;
        end
      end
      ST_RESTORE: begin
        if (cnt_q == RESTORE_LAST) state_nxt = ST_ON;
      end
      ST_ON: begin
        if (pwr_dn_req) state_nxt = ST_SAVE;
      end
      ST_SAVE: begin
        if (cnt_q == SAVE_LAST) begin
          state_nxt = ST_SLEEP;
          ctx_set   = 1'b1;
        end
      end
      ST_SLEEP: begin
        if (sack || cnt_q >= ACK_LAST) begin
          timeout_set = !sack;
          state_nxt   = ST_OFF;
        end
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // State, counter, synchroniser and outputs decoded from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_OFF;
      sync_q       <= 2'b00;
      cnt_q        <= '0;
      ctx_valid_q  <= 1'b0;
      rreg_save    <= 1'b0;
      rreg_restore <= 1'b0;
      pd_on        <= 1'b0;
      pd_busy      <= 1'b0;
      ack_timeout  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], sleep_ack};
      state_q <= state_nxt;
      if (state_nxt != state_q)          cnt_q <= '0;
      else if (counting && cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
      ctx_valid_q  <= ctx_valid_q | ctx_set;
      rreg_save    <= (state_nxt == ST_SAVE);
      rreg_restore <= (state_nxt == ST_RESTORE);
      pd_on        <= (state_nxt == ST_ON);
      pd_busy      <= (state_nxt == ST_WAKE) || (state_nxt == ST_RESTORE) ||
                      (state_nxt == ST_SAVE) || (state_nxt == ST_SLEEP);
      if (timeout_set)  ack_timeout <= 1'b1;
      else if (err_clr) ack_timeout <= 1'b0;
    end
  end

endmodule

// File: doc/dhm_pd_ctrl.md
Name: dhm_pd_ctrl

Overview:
- Power-down sequencer for one DHM core power domain.
- Drives the 3-bit pd_state, rreg_save and rreg_restore controls consumed by the domain's sleep/isolation logic.
- Takes sleep_ack back from the power switch chain.
- On a power-down request it saves retention registers, asserts sleep and waits for ack. Power-up reverses the order, with ack timeout detection.

Parameters:
- SAVE_CYCLES, 4: cycles rreg_save is held high; legal 1..255.
- RESTORE_CYCLES, 4: cycles rreg_restore is held high; legal 1..255.
- ACK_TIMEOUT, 200: max cycles to wait for the sleep_ack transition; legal 1..255.

Ports:
- clk  in  1  domain controller clock.
- reset_n  in  1  asynchronous active-low reset.
- pwr_dn_req  in  1  level request to power the domain down; sampled only in ON.
- pwr_up_req  in  1  level request to power the domain up; sampled only in OFF.
- sleep_ack  in  1  1 = all switches off, 0 = all switches on; asynchronous source, 2-flop synchronised internally.
- err_clr  in  1  single-cycle pulse clearing ack_timeout.
- pd_state  out  3  FSM state encoding; bit1 = 1 means domain powered (sleep deasserted).
- rreg_save  out  1  retention save strobe.
- rreg_restore  out  1  retention restore strobe.
- pd_on  out  1  high only in ON.
- pd_busy  out  1  high in WAKE, RESTORE, SAVE, SLEEP.
- ack_timeout  out  1  sticky error flag.

Behaviour:
- All outputs are registered. Reset values:
  - pd_state = 3'b000 (OFF)
  - rreg_save, rreg_restore, pd_on, pd_busy, ack_timeout = 0
  - internal ctx_valid = 0, counter = 0, synchroniser = 0
- The domain is powered down out of reset. Scan override is handled downstream.
- pd_state encoding:
  - OFF = 000
  - SLEEP = 001
  - WAKE = 010
  - RESTORE = 011
  - ON = 110
  - SAVE = 111
- Transitions (sack = synchronised sleep_ack, 2-cycle latency):
  - OFF: pwr_up_req = 1 -> WAKE, counter cleared.
  - WAKE: sack = 0 -> RESTORE if ctx_valid, else ON.
    - Counter reaches ACK_TIMEOUT first: set ack_timeout, take the same exit as sack = 0.
  - RESTORE: rreg_restore = 1 for exactly RESTORE_CYCLES cycles, then -> ON. ctx_valid is unchanged.
  - ON: pwr_dn_req = 1 -> SAVE.
  - SAVE: rreg_save = 1 for exactly SAVE_CYCLES cycles, then -> SLEEP, ctx_valid set to 1.
  - SLEEP: sack = 1 -> OFF.
    - Counter reaches ACK_TIMEOUT first: set ack_timeout, -> OFF.
- Strobe timing:
  - rreg_save/rreg_restore rise in the same cycle pd_state enters SAVE/RESTORE.
  - They fall in the same cycle pd_state leaves.
  - They are never high together, and never high outside those states.
- Requests:
  - Level sensitive.
  - Ignored in every state except the one listed above, including while pd_busy = 1.
  - A request held high re-triggers on the next visit to OFF/ON.
  - pwr_up_req and pwr_dn_req both high: only the one relevant to the current state acts.
- Counter:
  - 8 bits, increments each cycle in WAKE/SLEEP/SAVE/RESTORE.
  - Cleared on every state change.
  - Saturates; it never wraps.
- ack_timeout:
  - Set has priority over err_clr in the same cycle.
  - Once set, it stays high until err_clr.
- Asynchronous reset mid-sequence (any state): immediate return to OFF with all outputs at reset values. ctx_valid is cleared, so the next power-up skips RESTORE.
- Minimum latencies:
  - pwr_dn_req to SLEEP: SAVE_CYCLES + 1 cycles.
  - sack transition to exit of WAKE/SLEEP: 1 cycle after sack changes.

Test Plan:
1. Reset release, pwr_up_req = 1, sleep_ack drops to 0 at cycle 5 -> OFF, WAKE, then ON 3 cycles after the ack drop. rreg_restore never asserted (ctx_valid = 0); pd_on = 1.
2. From ON, pwr_dn_req pulse; sleep_ack rises 10 cycles later -> SAVE with rreg_save high exactly 4 cycles, then SLEEP (pd_state = 001), then OFF 3 cycles after ack; pd_busy high throughout.
3. Power up again after step 2 -> WAKE, RESTORE with rreg_restore high exactly 4 cycles, then ON; rreg_save stays 0.
4. sleep_ack held 1 in WAKE -> ack_timeout set after 200 cycles, FSM still proceeds to RESTORE/ON. err_clr pulse clears it; err_clr coincident with a new timeout leaves it set.
5. pwr_dn_req asserted during WAKE and RESTORE and released before ON -> ignored, remains ON. Held through ON -> SAVE entered on the first ON cycle after.
6. reset_n asserted mid-SAVE (cycle 2 of 4) -> rreg_save and pd_state go to 0 asynchronously. Next power-up goes WAKE to ON with no restore.
